// File: rtl/jtcontra_snd_pkg.sv
// Shared types and constants for the jtcontra stereo sound output stage.
package jtcontra_snd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAP  = 3'd1,
    DCL  = 3'd2,
    DCR  = 3'd3,
    MULL = 3'd4,
    MULR = 3'd5,
    OUT  = 3'd6
  } snd_state_t;

  localparam int GAIN_FRAC = 4;
  localparam int YACC_W    = 26;
  localparam int PROD_W    = 26;

  localparam logic signed [15:0] S16_MAX = 16'sh7FFF;
  localparam logic signed [15:0] S16_MIN = 16'sh8000;

endpackage

// File: rtl/jtcontra_snd_sat.sv
// Arithmetic right shift followed by saturation to a signed 16-bit word.
module jtcontra_snd_sat
  import jtcontra_snd_pkg::*;
#(
  parameter int IN_W  = 26,
  parameter int SHIFT = 8
) (
  input  logic signed [IN_W-1:0] din,
  output logic signed [15:0]     dout,
  output logic                   clip
);

  logic signed [IN_W-1:0] sh;
  logic [IN_W-16:0]       top;

  // The value fits in 16 bits only when every bit from 15 upward is a sign copy.
  always_comb begin
    sh   = din >>> SHIFT;
    top  = sh[IN_W-1:15];
    clip = !((&top) || !(|top));
    dout = sh[15:0];
    if (clip) dout = sh[IN_W-1] ? S16_MIN : S16_MAX;
  end

endmodule

// File: rtl/jtcontra_snd_out.sv
// Stereo sound output stage: capture, optional DC removal, shared-multiplier gain,
// saturation and clip hold. DC removal is built only when JTCONTRA_SNDOUT_DCRM_EN is defined.
module jtcontra_snd_out
  import jtcontra_snd_pkg::*;
#(
  parameter logic [15:0] PEAK_HOLD = 16'd2048,
  parameter int          DC_K      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample,
  input  logic signed [15:0] left,
  input  logic signed [15:0] right,
  input  logic        [7:0]  gain,
  output logic signed [15:0] snd_left,
  output logic signed [15:0] snd_right,
  output logic               sample_out,
  output logic               peak
);

  snd_state_t st;
  logic       pending;

  logic signed [15:0] x_l_p0, x_r_p0;
  logic        [7:0]  gain_p0;
  logic signed [15:0] y_l_p1, y_r_p1;
  logic               clip_dl_p1, clip_dr_p1;
  logic signed [15:0] o_l_p2, o_r_p2;
  logic               clip_l_p2, clip_r_p2;
  logic        [15:0] hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      pending <= 1'b0;
    end else begin
      case (st)
        IDLE:    if (sample) st <= CAP;
        CAP:     st <= DCL;
        DCL:     st <= DCR;
        DCR:     st <= MULL;
        MULL:    st <= MULR;
        MULR:    st <= OUT;
        OUT:     st <= (pending || sample) ? CAP : IDLE;
        default: st <= IDLE;
      endcase
      if (st == OUT)                     pending <= 1'b0;
      else if (st != IDLE && sample)     pending <= 1'b1;
    end
  end

  // Stage p0: capture inputs; gain is frozen here for the whole sample.
  always_ff @(posedge clk) begin
    if (st == CAP) begin
      x_l_p0  <= left;
      x_r_p0  <= right;
      gain_p0 <= gain;
    end
  end

  // Stage p1: DC removal, one channel per state.
`ifdef JTCONTRA_SNDOUT_DCRM_EN
  logic signed [15:0]       xprev_l, xprev_r, x_sel, xprev_sel, y_dc;
  logic signed [YACC_W-1:0] yacc_l, yacc_r, yacc_sel, yacc_nxt;
  logic signed [16:0]       d;
  logic                     clip_dc;

  always_comb begin
    x_sel     = (st == DCR) ? x_r_p0  : x_l_p0;
    xprev_sel = (st == DCR) ? xprev_r : xprev_l;
    yacc_sel  = (st == DCR) ? yacc_r  : yacc_l;
    d         = $signed({x_sel[15], x_sel}) - $signed({xprev_sel[15], xprev_sel});
    yacc_nxt  = yacc_sel - (yacc_sel >>> DC_K)
              + ($signed({{(YACC_W-17){d[16]}}, d}) <<< 8);
  end

  jtcontra_snd_sat #(.IN_W(YACC_W), .SHIFT(8)) u_sat_dc (
    .din  (yacc_nxt),
    .dout (y_dc),
    .clip (clip_dc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      xprev_l <= '0;
      xprev_r <= '0;
      yacc_l  <= '0;
      yacc_r  <= '0;
    end else if (st == DCL) begin
      xprev_l <= x_l_p0;
      yacc_l  <= yacc_nxt;
    end else if (st == DCR) begin
      xprev_r <= x_r_p0;
      yacc_r  <= yacc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (st == DCL) begin
      y_l_p1     <= y_dc;
      clip_dl_p1 <= clip_dc;
    end
    if (st == DCR) begin
      y_r_p1     <= y_dc;
      clip_dr_p1 <= clip_dc;
    end
  end
`else
  assign clip_dl_p1 = 1'b0;
  assign clip_dr_p1 = 1'b0;

  always_ff @(posedge clk) begin
    if (st == DCL) y_l_p1 <= x_l_p0;
    if (st == DCR) y_r_p1 <= x_r_p0;
  end
`endif

  // Stage p2: one 17x9 signed multiplier shared by both channels.
  logic signed [16:0]       mul_a;
  logic signed [8:0]        mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [15:0]       o_g;
  logic                     clip_g;

  always_comb begin
    mul_a = (st == MULR) ? $signed({y_r_p1[15], y_r_p1}) : $signed({y_l_p1[15], y_l_p1});
    mul_b = $signed({1'b0, gain_p0});
    prod  = mul_a * mul_b;
  end

  jtcontra_snd_sat #(.IN_W(PROD_W), .SHIFT(GAIN_FRAC)) u_sat_gain (
    .din  (prod),
    .dout (o_g),
    .clip (clip_g)
  );

  always_ff @(posedge clk) begin
    if (st == MULL) begin
      o_l_p2    <= o_g;
      clip_l_p2 <= clip_g | clip_dl_p1;
    end
    if (st == MULR) begin
      o_r_p2    <= o_g;
      clip_r_p2 <= clip_g | clip_dr_p1;
    end
  end

  // Output stage: peak reflects the hold count before this strobe's decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      snd_left   <= '0;
      snd_right  <= '0;
      sample_out <= 1'b0;
      peak       <= 1'b0;
      hold       <= '0;
    end else begin
      sample_out <= (st == OUT);
      if (st == OUT) begin
        snd_left  <= o_l_p2;
        snd_right <= o_r_p2;
        if (clip_l_p2 || clip_r_p2) begin
          hold <= PEAK_HOLD;
          peak <= 1'b1;
        end else begin
          peak <= (hold != 16'd0);
          if (hold != 16'd0) hold <= hold - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtcontra_snd_out.sv
// Self-checking bench for jtcontra_snd_out against a behavioural sample-level model.
`timescale 1ns/1ps
module tb_jtcontra_snd_out;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample;
  logic signed [15:0] left, right;
  logic        [7:0]  gain;
  logic signed [15:0] snd_left, snd_right;
  logic               sample_out, peak;

  jtcontra_snd_out dut (
    .clk        (clk),
    .rst        (rst),
    .sample     (sample),
    .left       (left),
    .right      (right),
    .gain       (gain),
    .snd_left   (snd_left),
    .snd_right  (snd_right),
    .sample_out (sample_out),
    .peak       (peak)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  longint m_xl, m_xr, m_yl, m_yr;
  int     m_hold;
  bit     m_peak;
  logic signed [15:0] obs_l, obs_r;
  logic               obs_peak;

  task automatic model_reset();
    m_xl = 0; m_xr = 0; m_yl = 0; m_yr = 0;
    m_hold = 0; m_peak = 0;
  endtask

  function automatic longint sat16(input longint v, output bit clip);
    clip = (v > 32767) || (v < -32768);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

`ifdef JTCONTRA_SNDOUT_DCRM_EN
  task automatic dc_step(input longint x, inout longint xp, inout longint ya,
                         output longint y, output bit clip);
    ya = ya - (ya >>> 8) + (x - xp) * 256;
    xp = x;
    y  = sat16(ya >>> 8, clip);
  endtask
`endif

  task automatic model_sample(input logic signed [15:0] l, input logic signed [15:0] r,
                              input logic [7:0] g, output logic signed [15:0] el,
                              output logic signed [15:0] er);
    longint lx, rx, yl, yr, ol, or_, gg;
    bit c1, c2, c3, c4;
    lx = l; rx = r; gg = g;
`ifdef JTCONTRA_SNDOUT_DCRM_EN
    dc_step(lx, m_xl, m_yl, yl, c1);
    dc_step(rx, m_xr, m_yr, yr, c2);
`else
    yl = lx; yr = rx; c1 = 0; c2 = 0;
`endif
    ol  = sat16((yl * gg) >>> 4, c3);
    or_ = sat16((yr * gg) >>> 4, c4);
    el = 16'(ol);
    er = 16'(or_);
    if (c1 || c2 || c3 || c4) begin
      m_peak = 1; m_hold = 2048;
    end else begin
      m_peak = (m_hold != 0);
      if (m_hold != 0) m_hold--;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One strobe; inputs held through the capture edge, then gain switched to g_after.
  task automatic send(input logic signed [15:0] l, input logic signed [15:0] r,
                      input logic [7:0] g, input logic [7:0] g_after, input string name);
    logic signed [15:0] el, er;
    int lat;
    model_sample(l, r, g, el, er);
    @(negedge clk);
    left = l; right = r; gain = g; sample = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) gain = g_after;
      if (sample_out) begin lat = k; break; end
    end
    obs_l = snd_left; obs_r = snd_right; obs_peak = peak;
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL %s latency: got %0d want 6", name, lat); end
    checks++;
    if (snd_left !== el) begin failures++; $display("FAIL %s left: got %h want %h", name, snd_left, el); end
    checks++;
    if (snd_right !== er) begin failures++; $display("FAIL %s right: got %h want %h", name, snd_right, er); end
    checks++;
    if (peak !== m_peak) begin failures++; $display("FAIL %s peak: got %b want %b", name, peak, m_peak); end
    @(posedge clk); #1;
    checks++;
    if (sample_out !== 1'b0 || snd_left !== el) begin
      failures++; $display("FAIL %s hold: sample_out=%b left=%h want 0/%h", name, sample_out, snd_left, el);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (snd_left !== 16'h0)  begin failures++; $display("FAIL reset_left: got %h want 0", snd_left); end
    checks++; if (snd_right !== 16'h0) begin failures++; $display("FAIL reset_right: got %h want 0", snd_right); end
    checks++; if (sample_out !== 1'b0) begin failures++; $display("FAIL reset_sample_out: got %b want 0", sample_out); end
    checks++; if (peak !== 1'b0)       begin failures++; $display("FAIL reset_peak: got %b want 0", peak); end
  endtask

  task automatic test_unity();
    do_reset();
    send(16'sh1234, -16'sh1234, 8'h10, 8'h10, "unity");
    checks++;
    if (obs_l !== 16'h1234 || obs_r !== 16'hEDCC || obs_peak !== 1'b0) begin
      failures++; $display("FAIL unity_vec: got %h/%h/%b want 1234/edcc/0", obs_l, obs_r, obs_peak);
    end
  endtask

  task automatic test_mute_gain_latch();
    send(16'sh7000, -16'sh6000, 8'h00, 8'h10, "mute");
    checks++;
    if (obs_l !== 16'h0 || obs_r !== 16'h0) begin
      failures++; $display("FAIL mute_vec: got %h/%h want 0/0", obs_l, obs_r);
    end
    send(16'sh0100, -16'sh0100, 8'h10, 8'hF0, "gain_latch");
  endtask

  task automatic test_clip_peak();
    bit p2048, p2049;
    do_reset();
    send(16'sh5000, 16'sh0000, 8'h20, 8'h20, "clip");
    checks++;
    if (obs_l !== 16'h7FFF || obs_peak !== 1'b1) begin
      failures++; $display("FAIL clip_vec: got %h/%b want 7fff/1", obs_l, obs_peak);
    end
    p2048 = 0; p2049 = 1;
    for (int i = 1; i <= 2049; i++) begin
      send(16'sh0000, 16'sh0000, 8'h10, 8'h10, "peak_hold");
      if (i == 2048) p2048 = obs_peak;
      if (i == 2049) p2049 = obs_peak;
    end
    checks++;
    if (p2048 !== 1'b1 || p2049 !== 1'b0) begin
      failures++; $display("FAIL peak_edges: got %b/%b want 1/0", p2048, p2049);
    end
  endtask

`ifdef JTCONTRA_SNDOUT_DCRM_EN
  task automatic test_dc_decay();
    logic signed [15:0] first, prev;
    int bad;
    do_reset();
    bad = 0; prev = 16'sh7FFF; first = 16'sh0;
    for (int i = 0; i < 4000; i++) begin
      send(16'sh1000, 16'sh1000, 8'h10, 8'h10, "dc");
      if (i == 0) first = obs_l;
      if (obs_l > prev || obs_l < 0) bad++;
      prev = obs_l;
    end
    checks++;
    if (first !== 16'sh1000) begin failures++; $display("FAIL dc_first: got %h want 1000", first); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL dc_monotonic: got %0d violations want 0", bad); end
    checks++;
    if (prev >= 16 || prev <= -16) begin failures++; $display("FAIL dc_final: got %0d want |x|<16", prev); end
  endtask
`endif

  task automatic test_back_to_back();
    logic signed [15:0] ea_l, ea_r, eb_l, eb_r;
    int n, t0, t1;
    model_sample(16'sh0800, 16'sh0400, 8'h18, ea_l, ea_r);
    model_sample(-16'sh0300, 16'sh1100, 8'h08, eb_l, eb_r);
    n = 0; t0 = -1; t1 = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 0) begin left = 16'sh0800; right = 16'sh0400; gain = 8'h18; end
      if (c == 2) begin left = -16'sh0300; right = 16'sh1100; gain = 8'h08; end
      sample = (c == 0 || c == 2 || c == 3);
      @(posedge clk); #1;
      if (sample_out) begin
        n++;
        if (n == 1) begin
          t0 = c;
          checks++;
          if (snd_left !== ea_l || snd_right !== ea_r) begin
            failures++; $display("FAIL b2b_first: got %h/%h want %h/%h", snd_left, snd_right, ea_l, ea_r);
          end
        end else if (n == 2) begin
          t1 = c;
          checks++;
          if (snd_left !== eb_l || snd_right !== eb_r) begin
            failures++; $display("FAIL b2b_second: got %h/%h want %h/%h", snd_left, snd_right, eb_l, eb_r);
          end
        end
      end
    end
    checks++;
    if (n != 2 || t0 != 6 || t1 != 12) begin
      failures++; $display("FAIL b2b_timing: got n=%0d t=%0d,%0d want n=2 t=6,12", n, t0, t1);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    left = 16'sh2222; right = 16'sh3333; gain = 8'h30; sample = 1'b1;
    @(posedge clk);
    @(negedge clk); sample = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (sample_out) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL abort_pulses: got %0d want 0", pulses); end
    checks++;
    if (snd_left !== 16'h0 || snd_right !== 16'h0 || peak !== 1'b0) begin
      failures++; $display("FAIL abort_outputs: got %h/%h/%b want 0/0/0", snd_left, snd_right, peak);
    end
    send(16'sh0400, -16'sh0200, 8'h10, 8'h10, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), 16'($urandom), 8'($urandom_range(0, 255)), 8'($urandom), "random");
    end
  endtask

  initial begin
    rst = 1'b1; sample = 1'b0; left = '0; right = '0; gain = 8'h10;
    test_reset();
    test_unity();
    test_mute_gain_latch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_clip_peak();
`ifdef JTCONTRA_SNDOUT_DCRM_EN
    test_dc_decay();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtcontra_snd_out.md
# jtcontra_snd_out

Stereo sound output stage between the JT51 sound block and the platform audio mixer. On each `sample` strobe it captures the FM left/right words and runs them through an optional DC-removal filter. It then applies a runtime gain with saturation, flags clipping on `peak` with a hold time, and presents registered outputs with a fixed-latency output strobe. One multiplier is shared between the two channels by a small sequencer.

## Interface
- `PEAK_HOLD`, 16'd2048 — number of output samples `peak` stays high after the last clipped sample (≥1)
- `DC_K`, 8 — DC filter pole shift, y leak = y>>>DC_K
- `clk` in 1 — 24 MHz system clock
- `rst` in 1 — synchronous, active-high reset
- `sample` in 1 — one-cycle strobe: `left`/`right` hold a new sample
- `left` in 16 — signed FM left sample
- `right` in 16 — signed FM right sample
- `gain` in 8 — unsigned 4.4 fixed point, 8'h10 = unity, 8'h00 = mute
- `snd_left` out 16 — signed processed left
- `snd_right` out 16 — signed processed right
- `sample_out` out 1 — one-cycle strobe, new `snd_left`/`snd_right` valid
- `peak` out 1 — clip indicator with hold

## Operation
- FSM states: IDLE, CAP, DCL, DCR, MULL, MULR, OUT.
- IDLE→CAP on `sample`. CAP latches `left`, `right`, `gain`. Then DCL→DCR→MULL→MULR→OUT→IDLE, one state per clk, unconditionally.
- DC filter per channel, state `xprev` (16b) and `yacc` (26b signed, y·2^8):
  - `d = x − xprev` (17b)
  - `yacc ← yacc − (yacc>>>DC_K) + (d<<8)`
  - `xprev ← x`
  - filter output `y = sat16(yacc>>>8)`
- Gain stage: `p = y · {1'b0,gain}` (25b signed). `o = sat16(p>>>4)`, truncation toward −∞.
- `sat16` clamps to [−32768, 32767] and sets a clip flag.
- In OUT: `snd_left`/`snd_right` register the results and `sample_out` pulses. If either clip flag is set, the hold counter loads PEAK_HOLD, else it decrements to 0 on each `sample_out`. `peak` = (counter≠0).
- `sample` while not IDLE:
  - sets a one-deep `pending` flag; further strobes while pending are dropped.
  - in OUT, if pending, FSM goes directly to CAP and clears pending. The pending sample uses the inputs present at that CAP.
- `gain` changes only take effect at CAP; there is no mid-sample glitch.

## Timing
- Reset: `snd_left`=0, `snd_right`=0, `sample_out`=0, `peak`=0, hold counter=0, `xprev`=`yacc`=0, pending=0, FSM=IDLE.
- Latency is fixed: `sample` high at edge n → `sample_out` high for exactly the cycle after edge n+6, and outputs change at the same edge.
- Back-to-back: minimum service interval is 6 clk. A pending sample yields `sample_out` 6 clk after the previous one.
- Reset mid-sequence aborts it: no `sample_out`, and filter state clears.
- Outputs hold between strobes.

## Configuration
- `JTCONTRA_SNDOUT_DCRM_EN` defined: DC filter active as above.
- Undefined: DCL/DCR states still walked (latency unchanged), `y = x`, filter registers not instantiated, and the gain stage is unchanged.

## Structure
- Package `jtcontra_snd_pkg`: FSM state enum, `GAIN_FRAC=4`, `YACC_W=26`, 16-bit min/max constants.
- Sub-module `jtcontra_snd_sat`: combinational arithmetic-shift + saturate to 16b with clip flag. It is instantiated for the DC output and the gain output.
- Single shared 17×9 signed multiplier, muxed by FSM state.

## Test plan
- Macro off, gain=8'h10, left=16'h1234, right=16'hEDCC, one `sample` → `sample_out` 6 clk later, `snd_left`=16'h1234, `snd_right`=16'hEDCC, `peak`=0.
- Macro off, gain=8'h20, left=16'h5000 → `snd_left`=16'h7FFF. `peak` rises with that `sample_out`, stays high for 2048 further strobes, drops on strobe 2049 if no new clips.
- Macro on, constant left=16'h1000 for 4000 samples at gain 8'h10 → first `snd_left`=16'h1000, then decays monotonically toward 0. Below ±16 after 4000 samples.
- Two `sample` strobes 2 clk apart, then a third 1 clk later → exactly two `sample_out`, 6 clk apart. The third is dropped.
- `rst` asserted in state MULL → no `sample_out`, all outputs 0. The next `sample` is processed with a cleared filter state.
- gain=8'h00 → both outputs 0. gain changed between `sample` and OUT → old gain is used.
